led_breathe_pwm: RTL
====================

// Module: led_breathe_pwm
// PURPOSE
//  LED output stage for the iCE40 12 MHz board; drives the green LED and 4 red LEDs directly.
//  Replaces the raw counter-bit LED drive with a PWM "breathing" effect on the green LED
//  and a 4-step brightness bar graph on the red LEDs.
//  Internal prescaler sets the ramp rate; a 4-state FSM produces a triangular brightness profile.
// PARAMETERS
//  PWM_BITS    8      PWM counter and brightness level width; MAX = 2^PWM_BITS-1 (>=2)
//  STEP_DIV    46875  clk_in cycles per brightness step (>=1); 46875 @ 12 MHz = 256 steps/s
//  HOLD_STEPS  64     number of steps held at MAX and at 0 (>=1)
// PORTS
//  clk_in         in   1         12 MHz system clock
//  rst_in         in   1         synchronous reset, active-high
//  enable_in      in   1         1: ramp runs; 0: ramp frozen, PWM keeps running
//  led_green_out  out  1         PWM breathing output
//  led_red_out    out  4         bar graph of the currently applied duty
//  level_out      out  PWM_BITS  current brightness level (debug/observation)
// BEHAVIOUR
//  Single clock domain (clk_in); synchronous, active-high reset (rst_in). All outputs registered.
//  Reset state: pwm_cnt=0, prescaler=0, level=0, hold_cnt=0, duty_q=0, state=S_UP;
//   led_green_out=0, led_red_out=4'b0000, level_out=0. Reset mid-operation behaves the same:
//   outputs read 0 the cycle after rst_in is sampled high.
//  pwm_cnt: free-running, +1 every cycle, wraps from MAX to 0. Unaffected by enable_in.
//  Prescaler: counts 0..STEP_DIV-1 only while enable_in=1, then wraps to 0.
//   tick = enable_in & (prescaler==STEP_DIV-1). enable_in=0 holds the prescaler at its value.
//  FSM (all transitions and level/hold updates occur only on tick):
//   S_UP:      level+=1; if level==MAX-1 -> S_HOLD_HI, hold_cnt=0 (level enters S_HOLD_HI at MAX)
//   S_HOLD_HI: hold_cnt+=1; if hold_cnt==HOLD_STEPS-1 -> S_DOWN
//   S_DOWN:    level-=1; if level==1 -> S_HOLD_LO, hold_cnt=0 (level enters S_HOLD_LO at 0)
//   S_HOLD_LO: hold_cnt+=1; if hold_cnt==HOLD_STEPS-1 -> S_UP
//   level never wraps; the full period is 2*MAX + 2*HOLD_STEPS ticks.
//   Unreachable state encodings recover to S_UP with level=0.
//  level_out = level register (updates the cycle after tick).
//  Glitch-free duty: duty_q <= level only when pwm_cnt==MAX. A level change mid-period takes
//   effect at the next PWM period, which starts at pwm_cnt==0.
//  led_green_out <= (pwm_cnt < duty_q): 1-cycle latency. duty 0 = always off; MAX = high MAX/2^N.
//  led_red_out[i] <= (duty_q >= i*2^(PWM_BITS-2) + 1), i=0..3. Thresholds for N=8: 1, 65, 129, 193.
//  enable_in deasserted mid-ramp: level, state and hold_cnt freeze, and the LEDs continue
//   PWM at the frozen duty. Reasserting resumes the count from the held prescaler value.
// TESTING (bench params PWM_BITS=4, STEP_DIV=3, HOLD_STEPS=2; MAX=15)
//  1 Reset: rst_in=1 for 3 cycles mid-ramp (state S_DOWN, level=9) -> next cycle all outputs 0;
//    after release the FSM restarts from S_UP with level=0.
//  2 Ramp: enable_in=1 after reset -> level_out steps +1 every 3 cycles up to 15, holds 15 for
//    6 cycles, steps down to 0, holds 0 for 6 cycles, repeats (period 102 cycles).
//  3 PWM: freeze at level=4 (enable_in=0) -> led_green_out high exactly 4 of every 16 cycles,
//    high when pwm_cnt is 1..4 at the output (1-cycle latency).
//  4 Bar: duty_q=5 -> led_red_out=4'b0011; duty_q=15 -> 4'b1111; duty_q=0 -> 4'b0000;
//    duty_q=13 -> 4'b1111; duty_q=12 -> 4'b0111.
//  5 Duty boundary: level changes 6->7 while pwm_cnt=8 -> that period has 6 high cycles,
//    the next period has 7.
//  6 Freeze/resume: drop enable_in for 20 cycles while prescaler=1 -> no level change;
//    after reassert, the next tick comes 2 cycles later.

Source files
------------

// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm
//   LED output stage: a PWM "breathing" green LED plus a 4-step bar graph on
//   the red LEDs. A prescaler paces the brightness ramp, and a 4-state FSM
//   gives the ramp its triangular profile: up, hold high, down, hold low.
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous reset, active-high
//   enable_in      1: ramp advances; 0: ramp frozen while PWM keeps running
//   led_green_out  PWM output at the currently applied duty (registered)
//   led_red_out    bar graph of the applied duty; thresholds at quarter steps (registered)
//   level_out      current brightness level register
module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 46875,
    parameter int HOLD_STEPS = 64
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                enable_in,
    output logic                led_green_out,
    output logic [3:0]          led_red_out,
    output logic [PWM_BITS-1:0] level_out
);

    localparam int PRE_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam int QUARTER = 2 ** (PWM_BITS - 2);

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS-1:0] MAX_M1    = MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_HOLD_HI = 2'd1,
        S_DOWN    = 2'd2,
        S_HOLD_LO = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] level_q,     level_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [PWM_BITS-1:0] duty_q,      duty_d;
    logic                green_q,     green_d;
    logic [3:0]          red_q,       red_d;
    logic                tick;

    assign tick = enable_in && (prescaler_q == PRE_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        level_d     = level_q;
        hold_cnt_d  = hold_cnt_q;
        prescaler_d = prescaler_q;
        // MAX is all ones, so the natural binary wrap gives MAX -> 0.
        pwm_cnt_d   = pwm_cnt_q + 1'b1;

        if (enable_in) begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        end

        if (tick) begin
            case (state_q)
                S_UP: begin
                    level_d = level_q + 1'b1;
                    if (level_q == MAX_M1) begin
                        state_d    = S_HOLD_HI;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD_HI: begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) state_d = S_DOWN;
                end
                S_DOWN: begin
                    level_d = level_q - 1'b1;
                    if (level_q == ONE) begin
                        state_d    = S_HOLD_LO;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD_LO: begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) state_d = S_UP;
                end
                default: begin
                    state_d    = S_UP;
                    level_d    = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end

        // Duty is latched only at the last count of a period, so a level change
        // never splits a PWM period.
        duty_d  = (pwm_cnt_q == MAX) ? level_q : duty_q;
        green_d = (pwm_cnt_q < duty_q);
        for (int i = 0; i < 4; i++) begin
            red_d[i] = (int'(duty_q) >= i * QUARTER + 1);
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) begin
            state_q     <= S_UP;
            pwm_cnt_q   <= '0;
            prescaler_q <= '0;
            level_q     <= '0;
            hold_cnt_q  <= '0;
            duty_q      <= '0;
            green_q     <= 1'b0;
            red_q       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            pwm_cnt_q   <= pwm_cnt_d;
            prescaler_q <= prescaler_d;
            level_q     <= level_d;
            hold_cnt_q  <= hold_cnt_d;
            duty_q      <= duty_d;
            green_q     <= green_d;
            red_q       <= red_d;
        end
    end

    assign led_green_out = green_q;
    assign led_red_out   = red_q;
    assign level_out     = level_q;

endmodule
